// File: rtl/video_line_fetch_rgb565.sv
// Line fetcher: pops one RGB565 word per active pixel, expands to RGB888, and re-times syncs by one cycle.
// Latency 1 cycle in to out; no backpressure from the display side, so an empty FIFO yields black pixels and sets underflow.
module video_line_fetch_rgb565 #(
    parameter int H_ACTIVE = 1920,
    parameter int V_ACTIVE = 1080
) (
    input  logic        rd_clk,
    input  logic        rd_rst,
    input  logic        vs_in,
    input  logic        hs_in,
    input  logic        de_in,
    input  logic [15:0] fifo_data,
    input  logic        fifo_vld,
    output logic        fifo_rd_en,
    output logic        vs_out,
    output logic        hs_out,
    output logic        de_out,
    output logic [23:0] rgb_out,
    output logic        frame_req,
    output logic        line_req,
    output logic        underflow,
    output logic        len_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_DE = 2'd1,
        S_LINE    = 2'd2
    } state_t;

    localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
    localparam logic [11:0] V_LIM = 12'(V_ACTIVE);

    state_t      state_q;
    logic        vs_prev_q;
    logic [11:0] line_cnt_q;
    logic [11:0] pix_cnt_q;
    logic        frame_req_q;
    logic        line_req_q;
    logic        underflow_q;
    logic        len_err_q;
    logic        vs_out_q;
    logic        hs_out_q;
    logic        de_out_q;
    logic [23:0] rgb_q;

    logic        frame_start;
    logic        fetching;
    logic        pix_room;
    logic        pop;
    logic        line_end;
    logic [11:0] line_cnt_inc;
    logic        more_lines;
    logic        line_req_d;
    logic [23:0] rgb_conv;
    logic [23:0] rgb_d;

    assign frame_start  = vs_in & ~vs_prev_q;
    assign fetching     = (state_q == S_WAIT_DE) || (state_q == S_LINE);
    assign pix_room     = pix_cnt_q < H_LIM;
    assign pop          = de_in & fetching & pix_room;
    assign line_end     = (state_q == S_LINE) & ~de_in;
    assign line_cnt_inc = line_cnt_q + 12'd1;
    assign more_lines   = line_cnt_inc < V_LIM;

    // A vs edge right after a line end would otherwise stretch line_req to two cycles.
    assign line_req_d   = (frame_start | (line_end & more_lines)) & ~line_req_q;

    // MSB replication keeps full-scale codes at full scale (5'h1F -> 8'hFF).
    assign rgb_conv = {fifo_data[15:11], fifo_data[15:13],
                       fifo_data[10:5],  fifo_data[10:9],
                       fifo_data[4:0],   fifo_data[4:2]};
    assign rgb_d    = (pop & fifo_vld) ? rgb_conv : 24'h000000;

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state_q     <= S_IDLE;
            vs_prev_q   <= 1'b0;
            line_cnt_q  <= 12'd0;
            pix_cnt_q   <= 12'd0;
            frame_req_q <= 1'b0;
            line_req_q  <= 1'b0;
            underflow_q <= 1'b0;
            len_err_q   <= 1'b0;
            vs_out_q    <= 1'b0;
            hs_out_q    <= 1'b0;
            de_out_q    <= 1'b0;
            rgb_q       <= 24'h000000;
        end else begin
            vs_prev_q   <= vs_in;
            vs_out_q    <= vs_in;
            hs_out_q    <= hs_in;
            de_out_q    <= de_in;
            rgb_q       <= rgb_d;
            frame_req_q <= frame_start;
            line_req_q  <= line_req_d;

            if (frame_start) begin
                state_q     <= S_WAIT_DE;
                line_cnt_q  <= 12'd0;
                pix_cnt_q   <= 12'd0;
                underflow_q <= 1'b0;
                len_err_q   <= 1'b0;
            end else begin
                if (pop) begin
                    pix_cnt_q <= pix_cnt_q + 12'd1;
                end
                if (pop && !fifo_vld) begin
                    underflow_q <= 1'b1;
                end
                if (de_in && fetching && !pix_room) begin
                    len_err_q <= 1'b1;
                end

                case (state_q)
                    S_WAIT_DE: begin
                        if (de_in) begin
                            state_q <= S_LINE;
                        end
                    end
                    S_LINE: begin
                        if (!de_in) begin
                            line_cnt_q <= line_cnt_inc;
                            pix_cnt_q  <= 12'd0;
                            if (pix_cnt_q != H_LIM) begin
                                len_err_q <= 1'b1;
                            end
                            state_q <= more_lines ? S_WAIT_DE : S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign fifo_rd_en = pop;
    assign vs_out     = vs_out_q;
    assign hs_out     = hs_out_q;
    assign de_out     = de_out_q;
    assign rgb_out    = rgb_q;
    assign frame_req  = frame_req_q;
    assign line_req   = line_req_q;
    assign underflow  = underflow_q;
    assign len_err    = len_err_q;

endmodule

// File: tb/tb_video_line_fetch_rgb565.sv
// Bench for video_line_fetch_rgb565 with H_ACTIVE=8, V_ACTIVE=4: frame-level reference model feeds
// expected pops/pixels into queues; a negedge monitor drains and compares them.
module tb_video_line_fetch_rgb565;

    localparam int H = 8;
    localparam int V = 4;

    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        vs_in = 1'b0;
    logic        hs_in = 1'b0;
    logic        de_in = 1'b0;
    logic [15:0] fifo_data = 16'h0;
    logic        fifo_vld = 1'b0;
    logic        fifo_rd_en;
    logic        vs_out;
    logic        hs_out;
    logic        de_out;
    logic [23:0] rgb_out;
    logic        frame_req;
    logic        line_req;
    logic        underflow;
    logic        len_err;

    video_line_fetch_rgb565 #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .vs_in     (vs_in),
        .hs_in     (hs_in),
        .de_in     (de_in),
        .fifo_data (fifo_data),
        .fifo_vld  (fifo_vld),
        .fifo_rd_en(fifo_rd_en),
        .vs_out    (vs_out),
        .hs_out    (hs_out),
        .de_out    (de_out),
        .rgb_out   (rgb_out),
        .frame_req (frame_req),
        .line_req  (line_req),
        .underflow (underflow),
        .len_err   (len_err)
    );

    always #5 rd_clk = ~rd_clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: frame/line bookkeeping in plain integers.
    bit m_active = 0, m_in_line = 0, m_prev_vs = 0, m_uf = 0, m_le = 0;
    int m_cnt = 0, m_lines = 0, m_frames = 0, m_lreqs = 0;
    bit e_uf = 0, e_le = 0, e_vs = 0, e_hs = 0, e_de = 0;
    logic [23:0] q_rgb[$];
    bit          q_pop[$];
    int obs_frames = 0, obs_lreqs = 0;
    bit prev_fr = 0, prev_lr = 0;
    logic [15:0] tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [23:0] conv(input logic [15:0] w);
        int r, g, b;
        r = int'(w[15:11]);
        g = int'(w[10:5]);
        b = int'(w[4:0]);
        r = r * 8 + r / 4;
        g = g * 4 + g / 16;
        b = b * 8 + b / 4;
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic cyc(input bit rst, input bit vs, input bit hs, input bit de,
                       input logic [15:0] d, input bit v);
        bit vs_rise, ep;
        int c0;
        if (rst && !rd_rst) q_rgb.delete();
        rd_rst = rst; vs_in = vs; hs_in = hs; de_in = de; fifo_data = d; fifo_vld = v;
        if (rst) begin
            m_active = 0; m_in_line = 0; m_prev_vs = 0; m_cnt = 0; m_lines = 0;
            m_uf = 0; m_le = 0;
            e_uf = 0; e_le = 0; e_vs = 0; e_hs = 0; e_de = 0;
            if (de) q_pop.push_back(1'b0);
        end else begin
            vs_rise = vs && !m_prev_vs;
            c0 = m_cnt;
            ep = de && m_active && (c0 < H);
            if (de) begin
                q_pop.push_back(ep);
                q_rgb.push_back((ep && v) ? conv(d) : 24'h0);
            end
            if (vs_rise) begin
                m_active = 1; m_in_line = 0; m_cnt = 0; m_lines = 0; m_uf = 0; m_le = 0;
                m_frames++; m_lreqs++;
            end else begin
                if (ep) m_cnt++;
                if (ep && !v) m_uf = 1;
                if (de && m_active && c0 >= H) m_le = 1;
                if (m_in_line && !de) begin
                    if (c0 != H) m_le = 1;
                    m_lines++; m_cnt = 0; m_in_line = 0;
                    if (m_lines < V) m_lreqs++;
                    else m_active = 0;
                end else if (de && m_active) begin
                    m_in_line = 1;
                end
            end
            m_prev_vs = vs;
        end
        @(posedge rd_clk);
        e_uf = m_uf; e_le = m_le;
        e_vs = rst ? 1'b0 : vs; e_hs = rst ? 1'b0 : hs; e_de = rst ? 1'b0 : de;
        #1;
    endtask

    always @(negedge rd_clk) begin
        chk("vs_out", vs_out, e_vs);
        chk("hs_out", hs_out, e_hs);
        chk("de_out", de_out, e_de);
        chk("underflow", underflow, e_uf);
        chk("len_err", len_err, e_le);
        if (de_in) begin
            if (q_pop.size() == 0) begin
                n_chk++;
                $display("FAIL pop_queue: empty while de_in high at %0t", $time);
            end else chk("fifo_rd_en", fifo_rd_en, q_pop.pop_front());
        end else chk("fifo_rd_en_idle", fifo_rd_en, 0);
        if (de_out) begin
            if (q_rgb.size() == 0) begin
                n_chk++;
                $display("FAIL rgb_queue: empty while de_out high at %0t", $time);
            end else chk("rgb_out", rgb_out, q_rgb.pop_front());
        end else chk("rgb_dark", rgb_out, 0);
        if (rd_rst) begin
            chk("rst_frame_req", frame_req, 0);
            chk("rst_line_req", line_req, 0);
        end
        if (frame_req) begin obs_frames++; chk("frame_req_width", prev_fr, 0); end
        if (line_req) begin obs_lreqs++; chk("line_req_width", prev_lr, 0); end
        prev_fr = frame_req;
        prev_lr = line_req;
    end

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 16'($urandom), 1);
    endtask

    task automatic vsync();
        cyc(0, 1, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 0, 16'h0, 1);
        idle(3);
    endtask

    // mode 0: random words with occasional empty FIFO; 1: fixed word; 2: conversion table
    task automatic line(input int len, input int mode, input logic [15:0] fw, input int kill);
        logic [15:0] d;
        bit v;
        for (int i = 0; i < len; i++) begin
            d = (mode == 0) ? 16'($urandom) : (mode == 1) ? fw : tbl[i % 4];
            v = (i != kill) && ((mode != 0) || ($urandom_range(0, 15) != 0));
            cyc(0, 0, 0, 1, d, v);
        end
        cyc(0, 0, 1, 0, 16'h0, 1);
        idle(2);
    endtask

    task automatic checkpoint(input string nm);
        idle(3);
        chk({nm, "_frame_reqs"}, obs_frames, m_frames);
        chk({nm, "_line_reqs"}, obs_lreqs, m_lreqs);
    endtask

    int base_l, base_f;

    initial begin
        tbl[0] = 16'h07E0; tbl[1] = 16'h001F; tbl[2] = 16'h0000; tbl[3] = 16'hFFFF;
        repeat (3) cyc(1, 0, 0, 0, 16'h0, 0);
        idle(2);

        // Normal frame, red
        base_f = obs_frames; base_l = obs_lreqs;
        vsync();
        repeat (V) line(H, 1, 16'hF800, -1);
        checkpoint("normal");
        chk("normal_frame_delta", obs_frames - base_f, 1);
        chk("normal_line_delta", obs_lreqs - base_l, 4);
        chk("normal_no_flags", {30'd0, underflow, len_err}, 0);

        // Conversion table
        vsync();
        line(H, 2, 16'h0, -1);
        repeat (V - 1) line(H, 1, 16'hFFFF, -1);
        checkpoint("conv");

        // Underflow on pixel 3 of line 0
        vsync();
        line(H, 1, 16'hF800, 3);
        repeat (V - 1) line(H, 1, 16'hF800, -1);
        checkpoint("uflow");
        chk("uflow_sticky", underflow, 1);
        vsync();
        chk("uflow_cleared", underflow, 0);
        repeat (V) line(H, 1, 16'h1234, -1);
        checkpoint("uflow_next");

        // Long and short lines
        vsync();
        line(10, 1, 16'hABCD, -1);
        line(6, 1, 16'h5555, -1);
        line(H, 1, 16'h5555, -1);
        line(H, 1, 16'h5555, -1);
        checkpoint("len");
        chk("len_err_sticky", len_err, 1);

        // vs rise in the middle of line 2
        vsync();
        line(H, 1, 16'h0F0F, -1);
        line(10, 1, 16'h0F0F, -1);
        repeat (4) cyc(0, 0, 0, 1, 16'h3333, 1);
        base_f = obs_frames; base_l = obs_lreqs;
        cyc(0, 1, 0, 1, 16'h3333, 1);
        cyc(0, 1, 0, 0, 16'h0, 1);
        idle(3);
        repeat (V) line(H, 0, 16'h0, -1);
        checkpoint("midvs");
        chk("midvs_frame_delta", obs_frames - base_f, 1);
        chk("midvs_line_delta", obs_lreqs - base_l, 4);

        // vs rise coinciding with de fall
        vsync();
        line(H, 1, 16'h7777, -1);
        repeat (H) cyc(0, 0, 0, 1, 16'h7777, 1);
        cyc(0, 1, 0, 0, 16'h0, 1);
        cyc(0, 1, 0, 0, 16'h0, 1);
        idle(3);
        repeat (V) line(H, 1, 16'h8888, -1);
        checkpoint("vs_vs_de");

        // Reset mid-line with de held high
        vsync();
        line(H, 1, 16'h4321, -1);
        repeat (4) cyc(0, 0, 0, 1, 16'h4321, 1);
        repeat (3) cyc(1, 0, 0, 1, 16'h4321, 1);
        chk("rst_rgb", rgb_out, 0);
        chk("rst_de_out", de_out, 0);
        repeat (4) cyc(0, 0, 0, 1, 16'h4321, 1);
        idle(2);
        line(H, 1, 16'h4321, -1);
        vsync();
        repeat (V) line(H, 1, 16'h2468, -1);
        checkpoint("rst");

        // Randomized frames
        repeat (6) begin
            vsync();
            repeat (V) line(($urandom_range(0, 3) == 0) ? $urandom_range(6, 10) : H, 0, 16'h0, -1);
            checkpoint("rand");
        end

        idle(4);
        chk("rgb_queue_drained", q_rgb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
